note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/music_pkg.sv | 23 ++
 rtl/note_sequencer_if.sv | 22 ++
 rtl/tone_gen.sv | 44 ++++
 rtl/note_sequencer.sv | 137 +++++++++++++
 tb/tb_note_sequencer.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the note sequencer: sequencer states, default timing
// parameters and a counter-width helper.
package music_pkg;

    localparam int unsigned DEF_NOTE_CYCLES = 12_500_000;
    localparam int unsigned DEF_GAP_CYCLES  = 2_500_000;
    localparam int unsigned DEF_BASE_DIV    = 3_000;
    localparam int unsigned NUM_NOTES       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, note-store read port and audio outputs of the note sequencer.
interface note_sequencer_if;

    logic       start;
    logic       stop;
    logic [3:0] note;
    logic [1:0] sel;
    logic       tone;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, note,
        input  sel, tone, busy, done
    );

    modport slave (
        input  start, stop, note,
        output sel, tone, busy, done
    );

endinterface

// File: rtl/tone_gen.sv
// Square-wave generator: toggles tone every half_period clocks while enabled,
// and holds tone and counter at zero while disabled.
module tone_gen #(
    parameter int unsigned HP_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [HP_W-1:0] half_period,
    output logic            tone
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            tone_q, tone_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cnt_d  = '0;
        tone_d = 1'b0;
        if (en) begin
            if (cnt_q == half_period - HP_W'(1)) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d  = cnt_q + HP_W'(1);
                tone_d = tone_q;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/note_sequencer.sv
// Plays the four notes of an external note store in order: LOAD, PLAY and GAP
// per note, then a one-cycle DONE pulse. stop and rst abort to IDLE.
module note_sequencer
    import music_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES = DEF_NOTE_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned BASE_DIV    = DEF_BASE_DIV
) (
    input logic             clk,
    input logic             rst,
    note_sequencer_if.slave bus
);

    localparam int NC_W = cnt_width(NOTE_CYCLES);
    localparam int GC_W = cnt_width(GAP_CYCLES);
    localparam int HP_W = $clog2(BASE_DIV * 16 + 1);

    localparam logic [NC_W-1:0] NOTE_LAST = NC_W'(NOTE_CYCLES - 1);
    localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(GAP_CYCLES - 1);
    localparam logic [1:0]      LAST_IDX  = 2'(NUM_NOTES - 1);

    seq_state_e      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      cur_note_q, cur_note_d;
    logic [NC_W-1:0] note_cnt_q, note_cnt_d;
    logic [GC_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [HP_W-1:0] half_period;
    logic            tone_en;
    logic            tone_w;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_note_d = cur_note_q;
        note_cnt_d = note_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    idx_d   = 2'd0;
                end
            end
            ST_LOAD: begin
                cur_note_d = bus.note;
                note_cnt_d = '0;
                state_d    = ST_PLAY;
            end
            ST_PLAY: begin
                if (note_cnt_q == NOTE_LAST) begin
                    note_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = ST_GAP;
                end else begin
                    note_cnt_d = note_cnt_q + NC_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GC_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // stop outranks everything, including a start seen in IDLE.
        if (bus.stop) begin
            state_d    = ST_IDLE;
            idx_d      = 2'd0;
            note_cnt_d = '0;
            gap_cnt_d  = '0;
        end

        sel_d  = (state_d == ST_IDLE) ? 2'd0 : idx_d;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            cur_note_q <= 4'd0;
            note_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sel_q      <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_note_q <= cur_note_d;
            note_cnt_q <= note_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign half_period = HP_W'(BASE_DIV) * (HP_W'(16) - HP_W'(cur_note_q));

    // Enable only between two PLAY cycles: tone starts low on entry and is
    // already low in the first cycle after PLAY ends or is aborted.
    assign tone_en = (state_q == ST_PLAY) && (state_d == ST_PLAY) && (cur_note_q != 4'd0);

    tone_gen #(
        .HP_W(HP_W)
    ) u_tone_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (tone_en),
        .half_period (half_period),
        .tone        (tone_w)
    );

    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.tone = tone_w;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with NOTE_CYCLES=20, GAP_CYCLES=4, BASE_DIV=1
// and note store {15,14,0,8}; one note slot is 25 cycles, a full sequence 101.
module tb_note_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [3:0] store [4] = '{4'd15, 4'd14, 4'd0, 4'd8};

    note_sequencer_if bus ();

    assign bus.note = store[bus.sel];

    note_sequencer #(
        .NOTE_CYCLES (20),
        .GAP_CYCLES  (4),
        .BASE_DIV    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed outputs packed as {busy, done, sel[1:0], tone}.
    function automatic logic [4:0] outs();
        return {bus.busy, bus.done, bus.sel, bus.tone};
    endfunction

    // Expected outputs j edges after the edge that sampled start:
    // slot n = j/25 has LOAD at offset 0, PLAY at 1..20, GAP at 21..24;
    // j=100 is DONE and j>100 is IDLE. A stop seen at sample s idles j>s.
    function automatic logic [4:0] exp_out(input int j, input int stop_at);
        int   n;
        int   ph;
        int   hp;
        logic t;
        if (stop_at >= 0 && j > stop_at) return 5'b0;
        if (j < 0 || j > 100) return 5'b0;
        if (j == 100) return 5'b11_11_0;
        n  = j / 25;
        ph = j % 25;
        t  = 1'b0;
        if (ph >= 1 && ph <= 20 && store[n] != 4'd0) begin
            hp = 16 - int'(store[n]);
            t  = (((ph - 1) / hp) % 2) == 1;
        end
        return {1'b1, 1'b0, 2'(n), t};
    endfunction

    // One start pulse followed by 102 sampled cycles; optionally a second start
    // pulse sampled at edge restart_at, or stop raised after sample stop_at.
    task automatic run_seq(input string tag, input int restart_at, input int stop_at);
        int dones;
        int done_at;
        dones   = 0;
        done_at = -1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int j = 0; j <= 101; j++) begin
            @(negedge clk);
            check($sformatf("%s j=%0d", tag, j), int'(outs()), int'(exp_out(j, stop_at)));
            if (bus.done) begin
                dones++;
                done_at = j;
            end
            bus.start = (j == restart_at - 1);
            bus.stop  = (j == stop_at);
        end
        check({tag, " done count"}, dones, (stop_at < 0) ? 1 : 0);
        check({tag, " done cycle"}, done_at, (stop_at < 0) ? 100 : -1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        #3;
        check("reset outputs", int'(outs()), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", int'(outs()), 0);

        // Full sequence, then a duplicate start mid-playback, then a stop.
        run_seq("A", -1, -1);
        run_seq("B", 30, -1);
        run_seq("C", -1, 35);

        // Asynchronous reset during the second GAP (sel=1, busy=1).
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (47) @(negedge clk);
        check("D before rst", int'(outs()), int'(exp_out(47, -1)));
        #2;
        rst = 1'b1;
        #1;
        check("D async rst", int'(outs()), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("D idle after rst", int'(outs()), 0);
        end
        run_seq("D replay", -1, -1);

        // start and stop together in IDLE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        check("E start+stop", int'(outs()), 0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        @(negedge clk);
        check("E still idle", int'(outs()), 0);

        // start held for 300 cycles: sequences repeat every 102 cycles with a
        // single IDLE cycle between them.
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            check($sformatf("F j=%0d", j), int'(outs()), int'(exp_out(j % 102, -1)));
            if (j < 204 && bus.done) dones++;
            if (j == 299) bus.start = 1'b0;
        end
        check("F done count", dones, 2);
        for (int k = 0; k < 200 && bus.busy; k++) @(negedge clk);
        check("F drained", int'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
